// File: rtl/ps2_transmitter.sv
// ps2_transmitter: host-to-device PS/2 command byte sender with RTS, ACK check and timeouts
module ps2_transmitter #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int FILTER_CYCLES  = 19,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       kclk,
    input  logic       kdata,
    output logic       kclk_oe,
    output logic       kdata_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FW = $clog2(FILTER_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SEND, ACK, RELEASE} state_t;

    logic [1:0]    s1_q, s2_q, filt_q;
    logic [FW-1:0] fcnt_q [2];
    logic          kprev_q, fall_q;
    state_t        state_q, state_d;
    logic [9:0]    frame_q, frame_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          kclk_oe_q, kclk_oe_d, kdata_oe_q, kdata_oe_d;
    logic          done_q, done_d, err_q, err_d;
    logic          timeout;

    // bit 0 is the clock line, bit 1 the data line
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= 2'b11;
            s2_q    <= 2'b11;
            filt_q  <= 2'b11;
            kprev_q <= 1'b1;
            fall_q  <= 1'b0;
            for (int i = 0; i < 2; i++) fcnt_q[i] <= '0;
        end else begin
            s1_q    <= {kdata, kclk};
            s2_q    <= s1_q;
            kprev_q <= filt_q[0];
            fall_q  <= kprev_q & ~filt_q[0];
            for (int i = 0; i < 2; i++) begin
                if (s2_q[i] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == FW'(FILTER_CYCLES - 1)) begin
                    filt_q[i] <= s2_q[i];
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + 1'b1;
                end
            end
        end
    end

    // a fall in SEND/ACK restarts the timer, so it outranks a coincident timeout
    assign timeout = (state_q inside {SEND, ACK, RELEASE}) && timer_q == TW'(TIMEOUT_CYCLES - 1)
                     && !(fall_q && state_q != RELEASE);

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        cnt_d      = cnt_q;
        timer_d    = timer_q + TW'(timer_q != TW'(TIMEOUT_CYCLES));
        kclk_oe_d  = kclk_oe_q;
        kdata_oe_d = kdata_oe_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: if (tx_valid) begin
                state_d   = INHIBIT;
                frame_d   = {1'b1, ~^tx_data, tx_data};
                cnt_d     = '0;
                timer_d   = '0;
                kclk_oe_d = 1'b1;
            end
            INHIBIT: if (timer_q == TW'(INHIBIT_CYCLES - 1)) begin
                state_d    = RTS;
                kdata_oe_d = 1'b1;
            end
            RTS: begin
                state_d   = SEND;
                kclk_oe_d = 1'b0;
                timer_d   = '0;
            end
            SEND: if (fall_q) begin
                timer_d    = '0;
                kdata_oe_d = ~frame_q[0];
                frame_d    = frame_q >> 1;
                cnt_d      = cnt_q + 4'd1;
                state_d    = (cnt_q == 4'd9) ? ACK : SEND;
            end
            ACK: if (fall_q) begin
                timer_d = '0;
                err_d   = filt_q[1];
                state_d = filt_q[1] ? IDLE : RELEASE;
            end
            RELEASE: if (filt_q[0] && filt_q[1]) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (timeout) begin
            state_d    = IDLE;
            kclk_oe_d  = 1'b0;
            kdata_oe_d = 1'b0;
            done_d     = 1'b0;
            err_d      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            frame_q    <= '0;
            cnt_q      <= '0;
            timer_q    <= '0;
            kclk_oe_q  <= 1'b0;
            kdata_oe_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            cnt_q      <= cnt_d;
            timer_q    <= timer_d;
            kclk_oe_q  <= kclk_oe_d;
            kdata_oe_q <= kdata_oe_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign tx_ready = state_q == IDLE;
    assign busy     = state_q != IDLE;
    assign kclk_oe  = kclk_oe_q;
    assign kdata_oe = kdata_oe_q;
    assign tx_done  = done_q;
    assign tx_err   = err_q;
endmodule

// File: tb/tb_ps2_transmitter.sv
// tb_ps2_transmitter: directed bench with a wired-AND PS/2 device model
module tb_ps2_transmitter;
    localparam int INH = 100;
    localparam int FLT = 19;
    localparam int TMO = 2000;
    localparam int H   = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, kclk_oe, kdata_oe, busy, tx_done, tx_err;
    logic       dev_clk = 1'b1, dev_data = 1'b1;
    logic       kclk, kdata;
    int         vecs = 0, errs = 0;
    int         n_done = 0, n_err = 0, n_done_bad = 0;
    int         d0, e0, n;
    logic [9:0] cap;
    bit         ok;

    assign kclk  = dev_clk & ~kclk_oe;
    assign kdata = dev_data & ~kdata_oe;

    ps2_transmitter #(.INHIBIT_CYCLES(INH), .FILTER_CYCLES(FLT), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .kclk(kclk), .kdata(kdata), .kclk_oe(kclk_oe), .kdata_oe(kdata_oe), .busy(busy),
        .tx_done(tx_done), .tx_err(tx_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_done) begin
            n_done++;
            if (busy || !tx_ready || tx_err) n_done_bad++;
        end
        if (tx_err) n_err++;
    end

    task automatic tick(input int c);
        repeat (c) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        tx_data  = 8'hA5;
    endtask

    // waits for RTS, then clocks nf falls, sampling data on each rising edge
    task automatic device(input int nf, input bit ack, input bit glitch, output logic [9:0] c, output bit rdy);
        int w = 0;
        c = '0;
        while (!(kclk && !kdata) && w < 1000) begin
            tick(1);
            w++;
        end
        rdy = w < 1000;
        tick(H);
        for (int k = 1; k <= nf; k++) begin
            dev_clk = 1'b0;
            tick(H);
            dev_clk = 1'b1;
            tick(2);
            if (k <= 10) c[k-1] = kdata;
            if (k == 10 && ack) dev_data = 1'b0;
            if (k == 11) dev_data = 1'b1;
            if (glitch && k >= 2 && k <= 8) begin
                tick(10);
                dev_clk = 1'b0;
                tick(5);
                dev_clk = 1'b1;
                tick(H - 17);
            end else begin
                tick(H - 2);
            end
        end
    endtask

    initial begin
        tick(3);
        rst = 1'b0;
        tick(1);
        chk("reset_ready", 32'(tx_ready), 1);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_oe", 32'({kclk_oe, kdata_oe}), 0);
        chk("reset_pulses", 32'({tx_done, tx_err}), 0);

        // 0xED with ACK, stepping through inhibit and RTS
        d0 = n_done; e0 = n_err;
        accept(8'hED);
        chk("ed_ready_low", 32'(tx_ready), 0);
        chk("ed_busy_high", 32'(busy), 1);
        n = 0;
        while (kclk_oe && !kdata_oe && n < 1000) begin
            n++;
            tick(1);
        end
        chk("ed_inhibit_len", n, INH);
        chk("ed_rts_both", 32'({kclk_oe, kdata_oe}), 32'b11);
        tick(1);
        chk("ed_rts_release", 32'({kclk_oe, kdata_oe}), 32'b01);
        device(11, 1'b1, 1'b0, cap, ok);
        chk("ed_rts_seen", 32'(ok), 1);
        chk("ed_frame", 32'(cap), 10'h3ED);
        tick(100);
        chk("ed_done_cnt", n_done - d0, 1);
        chk("ed_err_cnt", n_err - e0, 0);
        chk("ed_ready", 32'(tx_ready), 1);
        chk("ed_oe", 32'({kclk_oe, kdata_oe}), 0);

        // 0xFF and 0x01 parity cases
        d0 = n_done;
        accept(8'hFF);
        device(11, 1'b1, 1'b0, cap, ok);
        tick(100);
        chk("ff_frame", 32'(cap), 10'h3FF);
        accept(8'h01);
        device(11, 1'b1, 1'b0, cap, ok);
        tick(100);
        chk("01_frame", 32'(cap), 10'h201);
        chk("ff01_done_cnt", n_done - d0, 2);

        // missing ACK
        d0 = n_done; e0 = n_err;
        accept(8'h55);
        device(11, 1'b0, 1'b0, cap, ok);
        tick(100);
        chk("noack_frame", 32'(cap), 10'h355);
        chk("noack_err_cnt", n_err - e0, 1);
        chk("noack_done_cnt", n_done - d0, 0);
        chk("noack_oe", 32'({kclk_oe, kdata_oe}), 0);

        // device stops after the 4th fall
        d0 = n_done; e0 = n_err;
        accept(8'h12);
        device(3, 1'b0, 1'b0, cap, ok);
        dev_clk = 1'b0;
        repeat (FLT + 3 + TMO) @(posedge clk);
        #1;
        chk("tmo_early", 32'(tx_err), 0);
        tick(1);
        chk("tmo_err", 32'(tx_err), 1);
        chk("tmo_oe", 32'({kclk_oe, kdata_oe}), 0);
        chk("tmo_ready", 32'(tx_ready), 1);
        dev_clk = 1'b1;
        tick(100);
        chk("tmo_err_cnt", n_err - e0, 1);
        chk("tmo_done_cnt", n_done - d0, 0);

        // reset after the 5th bit, then a clean 0xF4
        d0 = n_done; e0 = n_err;
        accept(8'h3A);
        device(5, 1'b0, 1'b0, cap, ok);
        chk("rst_in_send", 32'(busy), 1);
        rst = 1'b1;
        tick(1);
        chk("rst_oe", 32'({kclk_oe, kdata_oe}), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pulses", 32'({tx_done, tx_err}), 0);
        rst = 1'b0;
        tick(50);
        chk("rst_no_pulse", (n_done - d0) + (n_err - e0), 0);
        accept(8'hF4);
        device(11, 1'b1, 1'b0, cap, ok);
        tick(100);
        chk("f4_frame", 32'(cap), 10'h2F4);
        chk("f4_done_cnt", n_done - d0, 1);

        // kclk glitches plus a tx_valid while busy
        d0 = n_done; e0 = n_err;
        accept(8'h3C);
        tick(10);
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        device(11, 1'b1, 1'b1, cap, ok);
        tick(300);
        chk("glitch_frame", 32'(cap), 10'h33C);
        chk("glitch_done_cnt", n_done - d0, 1);
        chk("glitch_err_cnt", n_err - e0, 0);
        chk("done_busy_same_cycle", n_done_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/ps2_transmitter.md
Name: ps2_transmitter

Overview:
- Host-to-device PS/2 transmitter: sends one command byte, e.g. LED set 0xED or reset 0xFF, to a keyboard on the same PS/2 port the receive path listens on.
- Runs the request-to-send sequence, shifts out 8 data bits LSB-first, then odd parity and stop, and checks the device ACK.
- Drives the open-drain lines through active-high pull-low enables. The top level builds the tri-states.
- Asserts busy while active so the top level can gate the receive path.

Parameters:
- INHIBIT_CYCLES, 10000: clk cycles kclk is held low during request-to-send (100 us at 100 MHz).
- FILTER_CYCLES, 19: consecutive stable samples required before a filtered kclk/kdata value changes.
- TIMEOUT_CYCLES, 200000: max clk cycles between device clock falling edges, and for final line release (2 ms).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tx_data  in  8  byte to send, captured when tx_valid && tx_ready
- tx_valid  in  1  request to send tx_data
- tx_ready  out  1  high only in IDLE
- kclk  in  1  raw PS/2 clock line (async)
- kdata  in  1  raw PS/2 data line (async)
- kclk_oe  out  1  1 = pull kclk low; 0 = release
- kdata_oe  out  1  1 = pull kdata low; 0 = release
- busy  out  1  high in every state except IDLE
- tx_done  out  1  one-cycle pulse: byte sent and ACK received
- tx_err  out  1  one-cycle pulse: timeout or missing ACK

Behaviour:
- Input conditioning:
  - kclk and kdata each pass a 2-flop synchronizer, then a counter filter. The filtered value updates after FILTER_CYCLES consecutive equal samples.
  - fall = filtered kclk 1->0, registered as a one-cycle strobe.
  - Filter state resets to 1.
- Reset: tx_ready=1 (IDLE), all other outputs 0. The shift register, bit counter and timer clear.
- Reset mid-transfer releases both lines on the next edge with no tx_err.
- Frame: shift register {1'b1 stop, ~^tx_data odd parity, tx_data}, loaded on accept. Bit counter 0..9.
- FSM:
  - IDLE: tx_ready=1. On tx_valid, latch the frame and go to INHIBIT. Cycle after accept: tx_ready=0, busy=1.
  - INHIBIT: kclk_oe=1 for exactly INHIBIT_CYCLES cycles, then RTS.
  - RTS: kdata_oe=1 and kclk_oe=1 for 1 cycle, then kclk_oe=0 while kdata_oe stays 1. Go to SEND and clear the timer.
  - SEND: on each fall, kdata_oe = ~frame[cnt] and cnt increments, so the data line presents the current bit.
    - Falls 1-8 carry data bits 0-7, fall 9 parity, fall 10 stop (kdata_oe=0).
    - After the 10th fall, go to ACK.
  - ACK: on the next fall, sample filtered kdata.
    - 0: go to RELEASE.
    - 1: pulse tx_err, go to IDLE.
  - RELEASE: wait until filtered kclk=1 and kdata=1, then pulse tx_done and go to IDLE.
- Timeout:
  - In SEND, ACK and RELEASE, a timer counts clk cycles and clears on every fall (RELEASE: from entry).
  - When the timer reaches TIMEOUT_CYCLES: both oe=0, pulse tx_err, go to IDLE.
  - Timer width is $clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.
- tx_done and tx_err are mutually exclusive, one pulse per accepted request.
- tx_valid outside IDLE is ignored. It is not queued.
- tx_data changing after accept does not affect the frame.
- A fall in INHIBIT or RTS is ignored: the host holds the clock, so any fall there is a glitch.
- The same-cycle IDLE->INHIBIT transition on a fresh tx_valid after done/err is allowed (back-to-back).
- kclk_oe and kdata_oe are registered outputs. They never toggle combinationally.

Test Plan:
- Send 0xED against a device model clocking at 12 kHz with ACK:
  - kclk held low for 10000 cycles, then kdata low.
  - Device samples bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - tx_done pulses once. busy falls the same cycle, tx_ready returns.
- Send 0xFF: parity bit 1 (eight ones give odd parity 1)? No: eight ones are even, so parity=1. Send 0x01: parity=0. Device-captured frame must match in both cases.
- Device model omits the ACK (kdata stays 1 at 11th fall): tx_err pulses once, tx_done stays 0, both oe=0 afterwards.
- Device stops clocking after 4 falls: tx_err exactly TIMEOUT_CYCLES after the 4th fall strobe. Lines released, tx_ready=1.
- Assert rst in SEND after the 5th bit: next cycle kclk_oe=kdata_oe=0, busy=0, no tx_err or tx_done. A new send of 0xF4 then completes correctly.
- Inject 5-cycle glitches on kclk during SEND (FILTER_CYCLES=19): no extra bit shifted, frame unchanged. tx_valid pulsed while busy: ignored, exactly one tx_done.
